fp_result_drain: RTL

//  Consumer end of the filter pipeline's output bit vectors. Captures one set of INPUTS lane vectors
//  and reduces them to one vector (select/AND/OR). Drains the set bits as ascending IDs, one per

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_result_drain_ffs_enc.sv | 29 ++
 rtl/fp_result_drain.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and default sizes for the filter pipeline result path.
package fp_pkg;

  // Default geometry of the pipeline output vectors.
  localparam int FP_INPUTS           = 8;
  localparam int FP_BIT_VEC_SIZE     = 128;
  localparam int FP_BIT_VEC_SIZE_LOG = 7;

  // One bit per candidate ID.
  typedef logic [FP_BIT_VEC_SIZE-1:0] bitvec_t;

  // Lane combine operation. Encoding 3 is not named and behaves as CMB_SEL.
  typedef enum logic [1:0] {
    CMB_SEL = 2'd0,
    CMB_AND = 2'd1,
    CMB_OR  = 2'd2
  } combine_op_e;

  // Drain controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fp_result_drain_ffs_enc.sv
// Combinational find-first-set: index of the lowest set bit, whether any
// bit is set, and whether exactly one bit is set.
module ffs_enc #(
  parameter int W    = 128,
  parameter int LOGW = 7
) (
  input  logic [W-1:0]    vec,
  output logic [LOGW-1:0] idx,
  output logic            any,
  output logic            one_hot_only
);

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  logic [W-1:0] vec_minus_one;
  assign vec_minus_one = vec - W'(1);
  assign any           = |vec;
  assign one_hot_only  = any && ((vec & vec_minus_one) == '0);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = LOGW'(i);
      end
    end
  end

endmodule

// File: rtl/fp_result_drain.sv
// Result drain: captures one set of lane vectors, reduces them to a single
// vector, then hands out the set bits as ascending IDs over a valid/ready
// interface and finishes with a one-cycle done pulse carrying the count.
import fp_pkg::*;

module fp_result_drain #(
  parameter int INPUTS           = FP_INPUTS,
  parameter int BIT_VEC_SIZE     = FP_BIT_VEC_SIZE,
  parameter int BIT_VEC_SIZE_LOG = FP_BIT_VEC_SIZE_LOG,
  parameter int SEL_W            = $clog2(INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [INPUTS-1:0][BIT_VEC_SIZE-1:0]  in,
  input  logic [INPUTS-1:0]                    valid_in,
  output logic                                 in_ready,
  input  logic [1:0]                           combine_op,
  input  logic [SEL_W-1:0]                     sel,
  output logic [BIT_VEC_SIZE_LOG-1:0]          id_out,
  output logic                                 id_valid,
  input  logic                                 id_ready,
  output logic                                 id_last,
  output logic                                 done,
  output logic [BIT_VEC_SIZE_LOG:0]            count
);

  localparam int CW = BIT_VEC_SIZE_LOG + 1;

  drain_state_e              state_q, state_d;
  logic [BIT_VEC_SIZE-1:0]   vec_q, vec_d;
  logic [CW-1:0]             count_q, count_d;

  logic [BIT_VEC_SIZE-1:0]   red_and, red_or, reduced;
  logic                      capture_ok;

  logic [BIT_VEC_SIZE_LOG-1:0] ffs_idx;
  logic                        ffs_any;
  logic                        ffs_one;

  // AND and OR of all lanes, evaluated every cycle; only used on capture.
  always_comb begin
    red_and = '1;
    red_or  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      red_and = red_and & in[i];
      red_or  = red_or  | in[i];
    end
  end

  // Pick the reduced vector and the matching capture condition.
  always_comb begin
    reduced    = in[sel];
    capture_ok = valid_in[sel];
    if (combine_op == CMB_AND) begin
      reduced    = red_and;
      capture_ok = &valid_in;
    end else if (combine_op == CMB_OR) begin
      reduced    = red_or;
      capture_ok = &valid_in;
    end
  end

  // Lowest pending ID of the captured vector.
  ffs_enc #(
    .W    (BIT_VEC_SIZE),
    .LOGW (BIT_VEC_SIZE_LOG)
  ) u_ffs (
    .vec          (vec_q),
    .idx          (ffs_idx),
    .any          (ffs_any),
    .one_hot_only (ffs_one)
  );

  // Outputs come straight from registered state, so they cannot change
  // while the downstream stalls and they drop to idle values on reset.
  assign in_ready = (state_q == IDLE);
  assign id_valid = (state_q == SCAN) && ffs_any;
  assign id_out   = ffs_idx;
  assign id_last  = (state_q == SCAN) && ffs_one;
  assign done     = (state_q == DONE);
  assign count    = count_q;

  // Next-state logic for the drain controller, vector and count.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (capture_ok) begin
          vec_d   = reduced;
          count_d = '0;
          state_d = (|reduced) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (id_valid && id_ready) begin
          // Drop the lowest set bit; the next one is presented next cycle.
          vec_d   = vec_q & (vec_q - BIT_VEC_SIZE'(1));
          count_d = count_q + CW'(1);
          if (ffs_one) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      count_q <= count_d;
    end
  end

endmodule
